// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instr_loader_pkg;

  localparam int          BYTES_PER_WORD = 4;
  localparam logic [31:0] HALT_WORD_DEF  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface instr_mem_loader_if #(
  parameter int NB = 32
);
  logic [7:0]    i_rx_data;
  logic          i_rx_valid;
  logic          o_instruction_write;
  logic [NB-1:0] o_address_memory_ins;
  logic [NB-1:0] o_instruction;

  // loader side
  modport slave (
    input  i_rx_data, i_rx_valid,
    output o_instruction_write, o_address_memory_ins, o_instruction
  );

  // UART receiver / memory side
  modport master (
    output i_rx_data, i_rx_valid,
    input  o_instruction_write, o_address_memory_ins, o_instruction
  );
endinterface

// File: rtl/instr_mem_loader_byte_assembler.sv
// Big-endian byte-to-word assembler: keeps the first three bytes and presents
// the full word combinationally together with the fourth byte.
module byte_assembler
  import instr_loader_pkg::*;
#(
  parameter int NBYTES = BYTES_PER_WORD
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic [7:0]            i_data,
  output logic [8*NBYTES-1:0]   o_word,
  output logic                  o_word_ready
);
  localparam int CW = $clog2(NBYTES);
  localparam int SW = 8*(NBYTES-1);

  logic [SW-1:0] r_shift;
  logic [CW-1:0] r_cnt;

  assign o_word       = {r_shift, i_data};
  assign o_word_ready = i_valid && !i_clear && (r_cnt == CW'(NBYTES-1));

  // counter wraps naturally on the last byte, so the next word starts at 0
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_valid) begin
      r_shift <= o_word[SW-1:0];
      r_cnt   <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Fills the instruction memory from a UART byte stream, one word per write.
// Optional inter-byte timeout enabled by INSTR_MEM_LOADER_TIMEOUT_EN.
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int            NB             = 32,
  parameter int            TAM            = 256,
  parameter logic [NB-1:0] HALT_WORD      = NB'(HALT_WORD_DEF),
  parameter int            TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_load_start,
  instr_mem_loader_if.slave   bus,
  output logic                o_busy,
  output logic                o_load_done,
  output logic                o_mem_full,
`ifdef INSTR_MEM_LOADER_TIMEOUT_EN
  output logic                o_timeout,
`endif
  output logic [NB-1:0]       o_word_count
);
  localparam logic [NB-1:0] LAST_ADDR = NB'(BYTES_PER_WORD*(TAM-1));
  localparam logic [NB-1:0] ADDR_STEP = NB'(BYTES_PER_WORD);

  state_t        r_state;
  logic [NB-1:0] r_addr;
  logic [NB-1:0] r_waddr;
  logic [NB-1:0] r_instr;
  logic [NB-1:0] r_count;
  logic          r_wr;
  logic          r_busy;
  logic          r_done;
  logic          r_full;

  logic [NB-1:0] w_word;
  logic          w_word_ready;
  logic          w_finish;
  logic          w_rx_en;
  logic          w_clear;
  logic          w_abort;

  // a write that ends the session drops any byte arriving alongside it
  assign w_finish = (r_instr == HALT_WORD) || (r_addr == LAST_ADDR);
  assign w_rx_en  = bus.i_rx_valid &&
                    ((r_state == RECV) || ((r_state == WRITE) && !w_finish));
  assign w_clear  = (r_state == IDLE) || w_abort;

  byte_assembler #(.NBYTES(BYTES_PER_WORD)) u_asm (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (w_clear),
    .i_valid      (w_rx_en),
    .i_data       (bus.i_rx_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

`ifdef INSTR_MEM_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);

  logic [TW-1:0] r_idle_cnt;
  logic          r_timeout;

  assign w_abort   = (r_state == RECV) && !bus.i_rx_valid &&
                     (r_idle_cnt == TW'(TIMEOUT_CYCLES-1));
  assign o_timeout = r_timeout;

  // abort leaves RECV, so the counter never runs past the limit
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_abort;
      if ((r_state != RECV) || bus.i_rx_valid)
        r_idle_cnt <= '0;
      else
        r_idle_cnt <= r_idle_cnt + TW'(1);
    end
  end
`else
  logic w_unused_timeout_cfg;

  assign w_abort              = 1'b0;
  // keeps the timeout parameter referenced when the timer is not built
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_waddr <= '0;
      r_instr <= '0;
      r_count <= '0;
      r_wr    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_load_start) begin
            r_addr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= RECV;
          end
        end
        RECV: begin
          // word and address are latched here so they hold steady through WRITE and after
          if (w_word_ready) begin
            r_instr <= w_word;
            r_waddr <= r_addr;
            r_wr    <= 1'b1;
            r_state <= WRITE;
          end else if (w_abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        WRITE: begin
          r_count <= r_count + NB'(1);
          if (r_instr == HALT_WORD) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else if (r_addr == LAST_ADDR) begin
            r_full  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_addr  <= r_addr + ADDR_STEP;
            r_state <= RECV;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_instruction_write  = r_wr;
  assign bus.o_address_memory_ins = r_waddr;
  assign bus.o_instruction        = r_instr;
  assign o_busy                   = r_busy;
  assign o_load_done              = r_done;
  assign o_mem_full               = r_full;
  assign o_word_count             = r_count;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader (TAM=4, TIMEOUT_CYCLES=16).
module tb_instr_mem_loader;
  localparam int NB = 32;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_load_start = 1'b0;
  logic          o_busy, o_load_done, o_mem_full;
  logic [NB-1:0] o_word_count;
`ifdef INSTR_MEM_LOADER_TIMEOUT_EN
  logic          o_timeout;
`endif

  instr_mem_loader_if #(.NB(NB)) bus();

  instr_mem_loader #(
    .NB(NB), .TAM(4), .HALT_WORD(32'hFFFF_FFFF), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_load_start (i_load_start),
    .bus          (bus),
    .o_busy       (o_busy),
    .o_load_done  (o_load_done),
    .o_mem_full   (o_mem_full),
`ifdef INSTR_MEM_LOADER_TIMEOUT_EN
    .o_timeout    (o_timeout),
`endif
    .o_word_count (o_word_count)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;

  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic [31:0] cnt; logic full; } done_t;
  wr_t   wr_q[$];
  done_t done_q[$];
  wr_t   e;
  done_t d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // monitor: every write strobe and done pulse must match the next expectation
  always @(negedge i_clk) begin
    if (i_reset) begin
      if (bus.o_instruction_write) begin
        if (wr_q.size() == 0) check("unexpected_write", 32'(bus.o_instruction_write), 0);
        else begin
          e = wr_q.pop_front();
          check("wr_data", bus.o_instruction, e.data);
          check("wr_addr", bus.o_address_memory_ins, e.addr);
          check("wr_cycle", cyc, e.cyc);
        end
      end
      if (o_load_done) begin
        if (done_q.size() == 0) check("unexpected_done", 32'(o_load_done), 0);
        else begin
          d = done_q.pop_front();
          check("done_count", o_word_count, d.cnt);
          check("done_full", 32'(o_mem_full), 32'(d.full));
          check("done_busy", 32'(o_busy), 0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    @(posedge i_clk); #1;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
  endtask

  // expected write lands one cycle after the cycle carrying the 4th byte
  task automatic send_word(input logic [31:0] w, input logic [31:0] a);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) wr_q.push_back('{a, w, cyc + 1});
      send_byte(w[31-8*i -: 8]);
    end
  endtask

  task automatic start();
    i_load_start = 1'b1;
    @(posedge i_clk); #1;
    i_load_start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((wr_q.size() != 0 || done_q.size() != 0) && n < 50) begin
      @(posedge i_clk); #1;
      n++;
    end
    check(name, wr_q.size() + done_q.size(), 0);
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;

    // reset state
    idle(3);
    check("rst_busy",  32'(o_busy), 0);
    check("rst_done",  32'(o_load_done), 0);
    check("rst_full",  32'(o_mem_full), 0);
    check("rst_count", o_word_count, 0);
    check("rst_wr",    32'(bus.o_instruction_write), 0);
    check("rst_addr",  bus.o_address_memory_ins, 0);
    check("rst_instr", bus.o_instruction, 0);
`ifdef INSTR_MEM_LOADER_TIMEOUT_EN
    check("rst_timeout", 32'(o_timeout), 0);
`endif
    i_reset = 1'b1;
    idle(1);

    // bytes in IDLE are ignored
    send_byte(8'h12); send_byte(8'h34); idle(2);
    send_byte(8'h56); send_byte(8'h78); idle(2);
    check("idle_busy", 32'(o_busy), 0);

    // two-word load ending on HALT; a byte during the final write is dropped
    start();
    check("start_busy", 32'(o_busy), 1);
    send_word(32'h2008_0005, 32'd0);
    idle(2);
    send_word(32'hFFFF_FFFF, 32'd4);
    done_q.push_back('{32'd2, 1'b0});
    send_byte(8'h77);
    drain("t2_drain");
    check("hold_instr", bus.o_instruction, 32'hFFFF_FFFF);
    check("hold_addr",  bus.o_address_memory_ins, 32'd4);
    check("hold_count", o_word_count, 32'd2);

    // capacity: TAM=4 fills at byte address 12
    start();
    send_word(32'h0102_0304, 32'd0);  idle(1);
    send_word(32'h0506_0708, 32'd4);  idle(1);
    send_word(32'h090A_0B0C, 32'd8);  idle(1);
    send_word(32'h0D0E_0F10, 32'd12);
    done_q.push_back('{32'd4, 1'b1});
    drain("t3_drain");
    check("full_sticky", 32'(o_mem_full), 1);
    check("full_busy",   32'(o_busy), 0);

    // byte during WRITE becomes byte 0 of the next word
    start();
    check("full_cleared", 32'(o_mem_full), 0);
    send_word(32'h1122_3344, 32'd0);
    send_word(32'hAB01_0203, 32'd4);
    send_word(32'hFFFF_FFFF, 32'd8);
    done_q.push_back('{32'd3, 1'b0});
    drain("t4_drain");

    // reset mid-word aborts without a write
    start();
    send_byte(8'hDE); send_byte(8'hAD);
    i_reset = 1'b0;
    #2;
    check("midrst_busy",  32'(o_busy), 0);
    check("midrst_wr",    32'(bus.o_instruction_write), 0);
    check("midrst_count", o_word_count, 0);
    idle(1);
    i_reset = 1'b1;
    idle(1);
    start();
    send_word(32'hCAFE_BABE, 32'd0);
    idle(1);
    send_word(32'hFFFF_FFFF, 32'd4);
    done_q.push_back('{32'd2, 1'b0});
    drain("t5_drain");

`ifdef INSTR_MEM_LOADER_TIMEOUT_EN
    // timeout: one word, then a lone byte and silence
    begin
      int k;
      int hit;
      hit = 0;
      start();
      send_word(32'hDEAD_BEEF, 32'd0);
      idle(1);
      k = cyc;
      send_byte(8'h55);
      for (int i = 0; i < 40 && hit == 0; i++) begin
        @(negedge i_clk);
        if (o_timeout) hit = cyc;
      end
      check("to_seen",  32'(hit != 0), 1);
      check("to_delay", 32'((hit - k) == 16 || (hit - k) == 17), 1);
      check("to_busy",  32'(o_busy), 0);
      check("to_count", o_word_count, 32'd1);
      @(negedge i_clk);
      check("to_pulse", 32'(o_timeout), 0);
      idle(1);
      drain("t6_drain");
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
